// File: rtl/ahb_gpio_pkg.sv
// Shared definitions for the AHB-Lite GPIO block: register offsets, HTRANS
// encodings and the byte-lane helper used by the bus interface.
package ahb_gpio_pkg;

    localparam logic [5:0] OFF_DATA_IN    = 6'h00;
    localparam logic [5:0] OFF_DATA_OUT   = 6'h04;
    localparam logic [5:0] OFF_DIR        = 6'h08;
    localparam logic [5:0] OFF_OUT_SET    = 6'h0C;
    localparam logic [5:0] OFF_OUT_CLR    = 6'h10;
    localparam logic [5:0] OFF_IRQ_EN     = 6'h14;
    localparam logic [5:0] OFF_IRQ_TYPE   = 6'h18;
    localparam logic [5:0] OFF_IRQ_POL    = 6'h1C;
    localparam logic [5:0] OFF_IRQ_STATUS = 6'h20;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    // Little-endian byte lanes touched by a transfer of the given size.
    function automatic logic [3:0] lane_mask(input logic [2:0] hsize, input logic [1:0] addr);
        case (hsize)
            3'd0:    lane_mask = 4'b0001 << addr;
            3'd1:    lane_mask = addr[1] ? 4'b1100 : 4'b0011;
            default: lane_mask = 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/gpio_in_sync.sv
// Multi-stage input synchroniser with one extra flop holding the previous
// synchronised value, so the parent can detect edges.
module gpio_in_sync
    import ahb_gpio_pkg::*;
#(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] s,
    output logic [WIDTH-1:0] p
);

    logic [WIDTH-1:0] chain_q [STAGES];
    logic [WIDTH-1:0] prev_q;

    // Shift the pad value through the chain; remember last synchronised value.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) begin
                chain_q[i] <= '0;
            end
            prev_q <= '0;
        end else begin
            chain_q[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                chain_q[i] <= chain_q[i-1];
            end
            prev_q <= chain_q[STAGES-1];
        end
    end

    assign s = chain_q[STAGES-1];
    assign p = prev_q;

endmodule

// File: rtl/ahb_gpio_irq.sv
// AHB-Lite GPIO slave: per-pin direction, atomic set/clear of the output
// latch, synchronised inputs and maskable edge/level interrupts.
module ahb_gpio_irq
    import ahb_gpio_pkg::*;
#(
    parameter int unsigned       GPIO_W      = 32,
    parameter int unsigned       SYNC_STAGES = 2,
    parameter logic [GPIO_W-1:0] RST_DOUT    = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hsel,
    input  logic [1:0]        htrans,
    input  logic              hwrite,
    input  logic [31:0]       haddr,
    input  logic [2:0]        hsize,
    input  logic              hready_in,
    input  logic [31:0]       hwdata,
    output logic              hready_out,
    output logic [31:0]       hrdata,
    output logic [1:0]        hresp,
    input  logic [GPIO_W-1:0] gpio_i,
    output logic [GPIO_W-1:0] gpio_o,
    output logic [GPIO_W-1:0] gpio_oe,
    output logic              irq
);

    logic              accept;
    logic              wr_q, rd_q;
    logic [5:0]        addr_q;
    logic [3:0]        lanes_q;
    logic [5:0]        reg_addr;
    logic              wr_en;
    logic [31:0]       bmask32;
    logic [GPIO_W-1:0] wmask, wbits;

    logic [GPIO_W-1:0] s, p;
    logic [GPIO_W-1:0] dout_q, dir_q, en_q, type_q, pol_q, status_q;
    logic [GPIO_W-1:0] dout_d, dir_d, en_d, type_d, pol_d, status_d;
    logic [GPIO_W-1:0] clr, events;
    logic [GPIO_W-1:0] rdata_w;
    logic              irq_q;
    logic              unused_bits;

    assign unused_bits = ^{htrans[0], haddr[31:6], addr_q[1:0]};

    gpio_in_sync #(
        .WIDTH  (GPIO_W),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (gpio_i),
        .s   (s),
        .p   (p)
    );

    assign accept = hsel & htrans[1] & hready_in;

    // Capture the address phase whenever the bus advances.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
            addr_q  <= '0;
            lanes_q <= '0;
        end else if (hready_in) begin
            wr_q    <= accept & hwrite;
            rd_q    <= accept & ~hwrite;
            addr_q  <= haddr[5:0];
            lanes_q <= lane_mask(hsize, haddr[1:0]);
        end
    end

    assign reg_addr = {addr_q[5:2], 2'b00};
    assign wr_en    = wr_q & hready_in;

    // Expand byte-lane enables into a bit mask over the write data.
    always_comb begin
        bmask32 = '0;
        for (int i = 0; i < 4; i++) begin
            bmask32[8*i +: 8] = {8{lanes_q[i]}};
        end
    end

    assign wmask = bmask32[GPIO_W-1:0];
    assign wbits = hwdata[GPIO_W-1:0] & wmask;

    assign events = (type_q & ((pol_q & s & ~p) | (~pol_q & ~s & p)))
                  | (~type_q & ((pol_q & s) | (~pol_q & ~s)));

    // Register next-state: bus writes, then interrupt events (set beats W1C).
    always_comb begin
        dout_d = dout_q;
        dir_d  = dir_q;
        en_d   = en_q;
        type_d = type_q;
        pol_d  = pol_q;
        clr    = '0;
        if (wr_en) begin
            case (reg_addr)
                OFF_DATA_OUT:   dout_d = (dout_q & ~wmask) | wbits;
                OFF_DIR:        dir_d  = (dir_q & ~wmask) | wbits;
                OFF_OUT_SET:    dout_d = dout_q | wbits;
                OFF_OUT_CLR:    dout_d = dout_q & ~wbits;
                OFF_IRQ_EN:     en_d   = (en_q & ~wmask) | wbits;
                OFF_IRQ_TYPE:   type_d = (type_q & ~wmask) | wbits;
                OFF_IRQ_POL:    pol_d  = (pol_q & ~wmask) | wbits;
                OFF_IRQ_STATUS: clr    = wbits;
                default:        ;
            endcase
        end
        status_d = (status_q & ~clr) | events;
    end

    // Register state and the registered interrupt line.
    always_ff @(posedge clk) begin
        if (rst) begin
            dout_q   <= RST_DOUT;
            dir_q    <= '0;
            en_q     <= '0;
            type_q   <= '0;
            pol_q    <= '0;
            status_q <= '0;
            irq_q    <= 1'b0;
        end else begin
            dout_q   <= dout_d;
            dir_q    <= dir_d;
            en_q     <= en_d;
            type_q   <= type_d;
            pol_q    <= pol_d;
            status_q <= status_d;
            irq_q    <= |(status_q & en_q);
        end
    end

    // Read mux over current state; zero outside a read data phase.
    always_comb begin
        rdata_w = '0;
        case (reg_addr)
            OFF_DATA_IN:    rdata_w = s;
            OFF_DATA_OUT:   rdata_w = dout_q;
            OFF_DIR:        rdata_w = dir_q;
            OFF_IRQ_EN:     rdata_w = en_q;
            OFF_IRQ_TYPE:   rdata_w = type_q;
            OFF_IRQ_POL:    rdata_w = pol_q;
            OFF_IRQ_STATUS: rdata_w = status_q;
            default:        rdata_w = '0;
        endcase
        hrdata = rd_q ? 32'(rdata_w) : 32'h0;
    end

    assign hready_out = 1'b1;
    assign hresp      = 2'b00;
    assign gpio_o     = dout_q;
    assign gpio_oe    = dir_q;
    assign irq        = irq_q;

endmodule
